// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter type and helpers.
// Imported by the sync generator and the downstream pixel stages.
package vga_timing_pkg;

  localparam int CW = 11;

  localparam int CLK_DIV_DFLT = 4;

  localparam int H_PIXELS = 800;
  localparam int H_SP     = 96;
  localparam int H_BP     = 144;
  localparam int H_FP     = 784;

  localparam int V_LINES  = 521;
  localparam int V_SP     = 2;
  localparam int V_BP     = 31;
  localparam int V_FP     = 511;

  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    cnt_t hc;
    cnt_t vc;
    logic vidon;
  } pix_pos_t;

  // Half-open window test: lo <= v < hi, unsigned.
  function automatic logic in_span(
    input cnt_t v,
    input cnt_t lo,
    input cnt_t hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel clock-enable divider.
// Counts 0..DIV-1 and flags the last count as a one-clk tick.
module clk_en_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running modulo-DIV counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Gating with clr_n keeps tick low in reset even when DIV is 1.
  assign tick = clr_n & (cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters, syncs and visible window.
// All outputs except frame_start decode straight from the counters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DFLT,
  parameter int HPIXELS = H_PIXELS,
  parameter int VLINES  = V_LINES,
  parameter int HSP     = H_SP,
  parameter int HBP     = H_BP,
  parameter int HFP     = H_FP,
  parameter int VSP     = V_SP,
  parameter int VBP     = V_BP,
  parameter int VFP     = V_FP
) (
  input  logic          clk,
  input  logic          clr_n,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          vidon,
  output logic          pix_tick,
  output logic          frame_start
);

  localparam cnt_t HMAX  = cnt_t'(HPIXELS - 1);
  localparam cnt_t VMAX  = cnt_t'(VLINES - 1);
  localparam cnt_t HSP_C = cnt_t'(HSP);
  localparam cnt_t HBP_C = cnt_t'(HBP);
  localparam cnt_t HFP_C = cnt_t'(HFP);
  localparam cnt_t VSP_C = cnt_t'(VSP);
  localparam cnt_t VBP_C = cnt_t'(VBP);
  localparam cnt_t VFP_C = cnt_t'(VFP);

  logic tick;
  logic hwrap;
  logic vwrap;

  clk_en_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick)
  );

  assign pix_tick = tick;
  assign hwrap    = (hc == HMAX);
  assign vwrap    = (vc == VMAX);

  // Pixel counter advances once per tick.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc <= '0;
    end else if (tick) begin
      hc <= hwrap ? '0 : hc + 1'b1;
    end
  end

  // Line counter advances on the tick where the pixel counter wraps.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vc <= '0;
    end else if (tick && hwrap) begin
      vc <= vwrap ? '0 : vc + 1'b1;
    end
  end

  // Pulse in the clk after both counters return to the origin.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick & hwrap & vwrap;
    end
  end

  assign hsync = (hc >= HSP_C);
  assign vsync = (vc >= VSP_C);
  assign vidon = in_span(hc, HBP_C, HFP_C)
               & in_span(vc, VBP_C, VFP_C);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two scaled-down geometries (div 4 and 1)
// against a closed-form position model, with random async resets.
module tb_vga_sync_gen;

  localparam int DA = 4;
  localparam int DB = 1;
  localparam int HP = 20;
  localparam int VL = 12;
  localparam int HS = 3;
  localparam int HB = 5;
  localparam int HF = 17;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VF = 10;

  logic clk = 1'b0;
  logic clr_n = 1'b0;

  logic hsA, vsA, vidA, tkA, fsA;
  logic hsB, vsB, vidB, tkB, fsB;
  logic [10:0] hcA, vcA, hcB, vcB;
  logic [26:0] outsA, outsB;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int cyc = 0;

  int prevA = -1;
  int prevB = -1;
  int nfsA = 0;
  int nfsB = 0;
  int hlow = 0;
  int vcnt = 0;
  bit vfirst = 1'b1;
  int lasth = 0;
  int lastv = 0;

  vga_sync_gen #(
    .CLK_DIV (DA), .HPIXELS (HP), .VLINES (VL),
    .HSP (HS), .HBP (HB), .HFP (HF),
    .VSP (VS), .VBP (VB), .VFP (VF)
  ) dut_a (
    .clk         (clk),
    .clr_n       (clr_n),
    .hsync       (hsA),
    .vsync       (vsA),
    .hc          (hcA),
    .vc          (vcA),
    .vidon       (vidA),
    .pix_tick    (tkA),
    .frame_start (fsA)
  );

  vga_sync_gen #(
    .CLK_DIV (DB), .HPIXELS (HP), .VLINES (VL),
    .HSP (HS), .HBP (HB), .HFP (HF),
    .VSP (VS), .VBP (VB), .VFP (VF)
  ) dut_b (
    .clk         (clk),
    .clr_n       (clr_n),
    .hsync       (hsB),
    .vsync       (vsB),
    .hc          (hcB),
    .vc          (vcB),
    .vidon       (vidB),
    .pix_tick    (tkB),
    .frame_start (fsB)
  );

  assign outsA = {hsA, vsA, vidA, tkA, fsA, hcA, vcA};
  assign outsB = {hsB, vsB, vidB, tkB, fsB, hcB, vcB};

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Expected outputs after k clk edges out of reset, divide d.
  function automatic logic [26:0] model(input int kk, input int d);
    int t, p, h, v;
    logic tk, fs, hs, vs, vid;
    t   = kk / d;
    p   = t % (HP * VL);
    h   = p % HP;
    v   = p / HP;
    tk  = (kk % d) == d - 1;
    fs  = (kk % d == 0) && (t > 0) && (p == 0);
    hs  = h >= HS;
    vs  = v >= VS;
    vid = (h >= HB) && (h < HF) && (v >= VB) && (v < VF);
    return {hs, vs, vid, tk, fs, 11'(h), 11'(v)};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) k = 0;
    else k++;
  end

  always @(negedge clk) begin
    if (!clr_n) begin
      prevA  = -1;
      prevB  = -1;
      hlow   = 0;
      vcnt   = 0;
      vfirst = 1'b1;
      check("rstA", 32'(outsA), 32'd0);
      check("rstB", 32'(outsB), 32'd0);
    end else begin
      check("outA", 32'(outsA), 32'(model(k, DA)));
      check("outB", 32'(outsB), 32'(model(k, DB)));
      if (fsA) begin
        if (prevA >= 0)
          check("gapA", 32'(cyc - prevA), 32'(HP * VL * DA));
        prevA = cyc;
        nfsA++;
        check("vidcnt", 32'(vcnt), 32'((HF - HB) * (VF - VB)));
        check("vidlast", 32'(lasth * 4096 + lastv),
              32'((HF - 1) * 4096 + VF - 1));
        vcnt   = 0;
        vfirst = 1'b1;
      end
      if (fsB) begin
        if (prevB >= 0)
          check("gapB", 32'(cyc - prevB), 32'(HP * VL * DB));
        prevB = cyc;
        nfsB++;
      end
      if (tkA) begin
        if (!hsA) hlow++;
        if (vidA) begin
          if (vfirst)
            check("vidfirst", 32'({hcA, vcA}),
                  32'({11'(HB), 11'(VB)}));
          vfirst = 1'b0;
          vcnt++;
          lasth = int'(hcA);
          lastv = int'(vcA);
        end
        if (int'(hcA) == HP - 1) begin
          check("hlow", 32'(hlow), 32'(HS));
          hlow = 0;
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drop clr_n between edges, check immediate clear, then release.
  task automatic async_reset();
    @(posedge clk);
    #($urandom_range(1, 3));
    clr_n = 1'b0;
    #1;
    check("arstA", 32'(outsA), 32'd0);
    check("arstB", 32'(outsB), 32'd0);
    run($urandom_range(1, 3));
    @(negedge clk);
    #($urandom_range(1, 4));
    clr_n = 1'b1;
  endtask

  initial begin
    run(3);
    @(negedge clk);
    #2;
    clr_n = 1'b1;
    run(2500);
    for (int i = 0; i < 6; i++) begin
      run($urandom_range(50, 1500));
      async_reset();
    end
    run(2200);
    check("fs_seenA", 32'(nfsA >= 4), 32'd1);
    check("fs_seenB", 32'(nfsB >= 8), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal values are 1 to 16.
REQ-002 Parameter HPIXELS, default 800: pixel clocks per line.
REQ-003 Parameter VLINES, default 521: lines per frame.
REQ-004 Parameters HSP=96, HBP=144, HFP=784: horizontal sync width, back-porch end and front-porch start, all as hc values.
REQ-005 Parameters VSP=2, VBP=31, VFP=511: vertical sync width, back-porch end and front-porch start, all as vc values.
REQ-006 clk  in  1  system clock; one clock; all state updates on its rising edge.
REQ-007 clr_n  in  1  reset; asynchronous, active-low.
REQ-008 hsync  out  1  horizontal sync, active-low.
REQ-009 vsync  out  1  vertical sync, active-low.
REQ-010 hc  out  11  horizontal pixel counter (0..HPIXELS-1).
REQ-011 vc  out  11  vertical line counter (0..VLINES-1).
REQ-012 vidon  out  1  high while (hc,vc) lies in the visible area.
REQ-013 pix_tick  out  1  one-clk pulse marking each pixel-clock advance.
REQ-014 frame_start  out  1  one-clk pulse on the tick where hc and vc both wrap to 0.

Function
REQ-015 Divider: count 0..CLK_DIV-1 and wrap; pix_tick=1 in the clk where the count equals CLK_DIV-1; with CLK_DIV=1, pix_tick is constantly 1 after reset.
REQ-016 hc, vc: registered; they change only in a clk where pix_tick=1 and hold otherwise.
REQ-017 On a tick: if hc==HPIXELS-1, hc<=0, else hc<=hc+1.
REQ-018 vc increments only on the tick where hc wraps; if vc==VLINES-1 at that tick, vc<=0.
REQ-019 hsync = 0 iff hc < HSP; combinational from the hc register (zero added latency).
REQ-020 vsync = 0 iff vc < VSP; combinational from the vc register.
REQ-021 vidon = 1 iff HBP <= hc < HFP and VBP <= vc < VFP; this gives 640x480 visible pixels with the default parameters.
REQ-022 frame_start is registered; it is 1 in the clk following the tick that sets hc=0 and vc=0.
REQ-023 Counters are 11 bits wide and never exceed HPIXELS-1 or VLINES-1; compares are unsigned.
REQ-024 hc, vc and vidon stay mutually consistent in every cycle, so a downstream pixel stage sees aligned values.

Reset
REQ-025 While clr_n=0: divider=0, hc=0, vc=0, frame_start=0, pix_tick=0 (held low even when CLK_DIV=1); consequently hsync=0, vsync=0 and vidon=0.
REQ-026 Reset asserted mid-frame clears all state immediately, without waiting for a clock edge.
REQ-027 After clr_n rises, the first pix_tick occurs CLK_DIV clks later and hc becomes 1 on that edge.

Structure
REQ-028 Default timing constants and the counter width (11) live in the shared package vga_timing_pkg; the downstream pixel stages use the same package.
REQ-029 The tick divider is a sub-module named clk_en_div (parameter DIV, ports clk, clr_n, tick); the rest is flat.
REQ-030 No gated or derived clocks; pix_tick is used only as a clock enable.

Verification
REQ-031 Reset, then 4 clks with CLK_DIV=4 -> pix_tick pulses once in the 4th clk; hc=1 on the following edge.
REQ-032 Run one line -> hc goes 799->0 and vc goes 0->1 on the same tick; hsync is low for exactly 96 ticks per line.
REQ-033 Run one full frame -> 800*521=416800 ticks between frame_start pulses; vsync is low for 2 lines (1600 ticks).
REQ-034 Count vidon=1 ticks over one frame -> 307200 (640x480); vidon first goes high at hc=144, vc=31 and last is high at hc=783, vc=510.
REQ-035 Assert clr_n=0 at hc=400, vc=200, asynchronously between edges -> hc=0, vc=0 and vidon=0 before the next edge; timing restarts per REQ-027.
REQ-036 Rerun REQ-033 with CLK_DIV=1 -> pix_tick is constantly high after reset and frame_start occurs every 416800 clks.
